// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instructionList;

   // Canonical RISC-V NOP (addi x0, x0, 0), shown to decode when nothing is valid.
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered fetch result: the PC and the word fetched from it.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetchEntry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetchState_t;

   // Instruction addresses are word aligned; the low two bits are dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Small in-order FIFO of fetch entries with push, pop, flush and occupancy count.
// The head entry is visible combinationally so decode sees it in the same cycle.
module fetch_fifo
   import instructionList::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  fetchEntry_t                  push_data_i,
   input  logic                         pop_i,
   output fetchEntry_t                  head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o
);

   localparam int            CW         = $clog2(DEPTH+1);
   localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH-1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   fetchEntry_t   mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign do_pop  = pop_i & (count_q != '0);
   assign do_push = push_i & ((count_q != FULL_COUNT) | do_pop);

   // Pointer and occupancy update; a flush empties the queue and overrides push/pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      end
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Pointer/count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i && !reset) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential word fetches under a credit limit,
// pairs responses with their PCs and hands them to decode through a small FIFO.
// A redirect flushes buffered work and drops responses still in flight.
// Optional build macro FETCH_PERF_COUNTERS_EN adds fetchCount/stallCount outputs.
module fetch_stage
   import instructionList::*;
#(
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemReady,
   input  logic        imemRvalid,
   input  logic [31:0] imemRdata,
   input  logic        redirectValid,
   input  logic [31:0] redirectPc,
   output logic        idValid,
   input  logic        idReady,
   output logic [31:0] instructionSet,
   output logic [31:0] pcOut
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0] fetchCount,
   output logic [31:0] stallCount
`endif
);

   localparam int          CW           = $clog2(FIFO_DEPTH+1);
   localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

   fetchState_t   state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_count_q, drop_count_d;

   logic [CW-1:0] fifo_count, tag_count;
   logic          fifo_empty, tag_empty;
   fetchEntry_t   rsp_head, tag_head, rsp_entry, tag_entry;
   logic          pop, accept, rsp_seen, rsp_live;
   logic [CW:0]   credit_used;
   logic          unused_tag_bits;

   assign pop    = idValid & idReady;
   assign accept = imemReq & imemReady;
   // Any response to a request we issued; the IDLE cycle ignores the bus.
   assign rsp_seen = imemRvalid & (state_q != IDLE) & (outstanding_q != '0);
   // Only responses that still belong to the current stream are buffered.
   assign rsp_live = rsp_seen & (state_q == RUN) & ~redirectValid;

   // Slots committed to in-flight requests plus buffered entries, net of this cycle's pop.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
   assign imemReq     = (state_q == RUN) && (credit_used < CREDIT_LIMIT);
   assign imemAddr    = fetch_pc_q;

   // Next-state logic: sequential PC advance, flush bookkeeping and redirect handling.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      drop_count_d  = drop_count_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_seen);
      if (accept) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      case (state_q)
         IDLE:  state_d = RUN;
         RUN:   state_d = RUN;
         FLUSH: begin
            drop_count_d = drop_count_q - CW'(rsp_seen);
            if (drop_count_d == '0) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
      // Everything in flight after this edge belongs to the old stream and is dropped.
      if (redirectValid) begin
         fetch_pc_d   = align_pc(redirectPc);
         drop_count_d = outstanding_d;
         state_d      = (outstanding_d != '0) ? FLUSH : RUN;
      end
   end

   // State, PC and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_count_q  <= drop_count_d;
      end
   end

   // PC tags of accepted requests, in issue order; the instr field is not used.
   assign tag_entry = {fetch_pc_q, NOP_INSTR};

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_queue (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (redirectValid),
      .push_i      (accept),
      .push_data_i (tag_entry),
      .pop_i       (rsp_live),
      .head_o      (tag_head),
      .count_o     (tag_count),
      .empty_o     (tag_empty)
   );

   assign rsp_entry = {tag_head.pc, imemRdata};

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_rsp_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (redirectValid),
      .push_i      (rsp_live),
      .push_data_i (rsp_entry),
      .pop_i       (pop),
      .head_o      (rsp_head),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty)
   );

   assign unused_tag_bits = ^{tag_head.instr, tag_count, tag_empty};

   // Idle outputs show a NOP at PC 0 so decode never sees stale data.
   assign idValid        = ~fifo_empty;
   assign instructionSet = fifo_empty ? NOP_INSTR : rsp_head.instr;
   assign pcOut          = fifo_empty ? 32'h0 : rsp_head.pc;

`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] fetch_count_q, stall_count_q;

   // Free-running event counters for accepted fetches and decode stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         if (accept) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         if (idValid && !idReady) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign fetchCount = fetch_count_q;
   assign stallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, cycle-by-cycle bench for fetch_stage (FIFO_DEPTH=2, RESET_PC=0).
// Each record gives one cycle of inputs and the outputs expected in that cycle.
module tb_fetch_stage;
   import instructionList::*;

   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   logic        clk = 1'b0;
   logic        reset, imemReq, imemReady, imemRvalid, redirectValid, idValid, idReady;
   logic [31:0] imemAddr, imemRdata, redirectPc, instructionSet, pcOut;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] fetchCount, stallCount;
`endif

   always #5 clk = ~clk;

   fetch_stage #(.FIFO_DEPTH(2), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .reset          (reset),
      .imemReq        (imemReq),
      .imemAddr       (imemAddr),
      .imemReady      (imemReady),
      .imemRvalid     (imemRvalid),
      .imemRdata      (imemRdata),
      .redirectValid  (redirectValid),
      .redirectPc     (redirectPc),
      .idValid        (idValid),
      .idReady        (idReady),
      .instructionSet (instructionSet),
      .pcOut          (pcOut)
`ifdef FETCH_PERF_COUNTERS_EN
      ,
      .fetchCount     (fetchCount),
      .stallCount     (stallCount)
`endif
   );

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        idr;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        cd;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   step     = 0;

   function automatic vec_t vec(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] rdata, input logic redir,
                                input logic [31:0] rpc, input logic idr,
                                input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc,
                                input logic [31:0] ins, input logic cd);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.redir = redir;
      v.rpc = rpc; v.idr = idr; v.req = req; v.addr = addr; v.vld = vld;
      v.pc = pc; v.ins = ins; v.cd = cd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL step %0d %s: got %h expected %h", step, nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset         = v.rst;
      imemReady     = v.rdy;
      imemRvalid    = v.rv;
      imemRdata     = v.rdata;
      redirectValid = v.redir;
      redirectPc    = v.rpc;
      idReady       = v.idr;
   endtask

   task automatic apply(input vec_t v);
      drive(v);
      #1;
      chk("imemReq", 32'(imemReq), 32'(v.req));
      chk("imemAddr", imemAddr, v.addr);
      chk("idValid", 32'(idValid), 32'(v.vld));
      if (v.cd) begin
         chk("pcOut", pcOut, v.pc);
         chk("instructionSet", instructionSet, v.ins);
`ifdef FETCH_PERF_COUNTERS_EN
         if (!v.vld) begin
            chk("fetchCount", fetchCount, 32'h0);
            chk("stallCount", stallCount, 32'h0);
         end
`endif
      end
      $display("step %0d: req=%b addr=%h vld=%b pc=%h ins=%h", step, imemReq, imemAddr,
               idValid, pcOut, instructionSet);
      step++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      //          rst rdy rv  rdata          rd  rpc           idr  req addr          vld pc            ins            cd
      // Reset (after one unchecked reset edge) then stream with L=1.
      tbl.push_back(vec(Y, N, N, 32'h0,         N, 32'h0,        Y,  N, 32'h0,        N, 32'h0,        NOP_INSTR,     Y));
      tbl.push_back(vec(Y, N, N, 32'h0,         N, 32'h0,        Y,  N, 32'h0,        N, 32'h0,        NOP_INSTR,     Y));
      tbl.push_back(vec(N, Y, N, 32'h0,         N, 32'h0,        Y,  N, 32'h0,        N, 32'h0,        NOP_INSTR,     Y));
      tbl.push_back(vec(N, Y, N, 32'h0,         N, 32'h0,        Y,  Y, 32'h0,        N, 32'h0,        32'h0,         N));
      tbl.push_back(vec(N, Y, Y, 32'hA000_0000, N, 32'h0,        Y,  Y, 32'h4,        N, 32'h0,        32'h0,         N));
      tbl.push_back(vec(N, Y, Y, 32'hA000_0004, N, 32'h0,        Y,  Y, 32'h8,        Y, 32'h0,        32'hA000_0000, Y));
      tbl.push_back(vec(N, Y, Y, 32'hA000_0008, N, 32'h0,        Y,  Y, 32'hC,        Y, 32'h4,        32'hA000_0004, Y));
      // Back-pressure for six cycles: issue stops at two slots, head held.
      tbl.push_back(vec(N, Y, Y, 32'hA000_000C, N, 32'h0,        N,  N, 32'h10,       Y, 32'h8,        32'hA000_0008, Y));
      for (int i = 0; i < 5; i++) begin
         tbl.push_back(vec(N, Y, N, 32'h0,      N, 32'h0,        N,  N, 32'h10,       Y, 32'h8,        32'hA000_0008, Y));
      end
      // Release: PCs continue without skips or repeats.
      tbl.push_back(vec(N, Y, N, 32'h0,         N, 32'h0,        Y,  Y, 32'h10,       Y, 32'h8,        32'hA000_0008, Y));
      tbl.push_back(vec(N, Y, Y, 32'hA000_0010, N, 32'h0,        Y,  Y, 32'h14,       Y, 32'hC,        32'hA000_000C, Y));
      tbl.push_back(vec(N, Y, Y, 32'hA000_0014, N, 32'h0,        Y,  Y, 32'h18,       Y, 32'h10,       32'hA000_0010, Y));
      // Redirect + response + pop together; the response is discarded.
      tbl.push_back(vec(N, N, Y, 32'hA000_0018, Y, 32'h200,      Y,  Y, 32'h1C,       Y, 32'h14,       32'hA000_0014, Y));
      tbl.push_back(vec(N, Y, N, 32'h0,         N, 32'h0,        Y,  Y, 32'h200,      N, 32'h0,        32'h0,         N));
      tbl.push_back(vec(N, Y, Y, 32'hA000_0200, N, 32'h0,        Y,  Y, 32'h204,      N, 32'h0,        32'h0,         N));
      tbl.push_back(vec(N, N, Y, 32'hA000_0204, N, 32'h0,        Y,  Y, 32'h208,      Y, 32'h200,      32'hA000_0200, Y));
      tbl.push_back(vec(N, N, N, 32'h0,         N, 32'h0,        Y,  Y, 32'h208,      Y, 32'h204,      32'hA000_0204, Y));
      tbl.push_back(vec(N, N, N, 32'h0,         N, 32'h0,        Y,  Y, 32'h208,      N, 32'h0,        32'h0,         N));

      imemRdata = 32'h0;
      drive(vec(Y, N, N, 32'h0, N, 32'h0, Y, N, 32'h0, N, 32'h0, NOP_INSTR, N));
      @(posedge clk);
      @(negedge clk);

      foreach (tbl[i]) begin
         apply(tbl[i]);
      end

      // Redirect to 0x104 with two requests in flight, L=3.
      apply(vec(N, Y, N, 32'h0,         N, 32'h0,         Y, Y, 32'h208,       N, 32'h0, 32'h0, N));
      apply(vec(N, Y, N, 32'h0,         N, 32'h0,         Y, Y, 32'h20C,       N, 32'h0, 32'h0, N));
      apply(vec(N, Y, N, 32'h0,         Y, 32'h104,       Y, N, 32'h210,       N, 32'h0, 32'h0, N));
      apply(vec(N, Y, Y, 32'hDEAD_0208, N, 32'h0,         Y, N, 32'h104,       N, 32'h0, 32'h0, N));
      apply(vec(N, Y, Y, 32'hDEAD_020C, N, 32'h0,         Y, N, 32'h104,       N, 32'h0, 32'h0, N));
      apply(vec(N, Y, N, 32'h0,         N, 32'h0,         Y, Y, 32'h104,       N, 32'h0, 32'h0, N));
      apply(vec(N, N, N, 32'h0,         N, 32'h0,         Y, Y, 32'h108,       N, 32'h0, 32'h0, N));
      apply(vec(N, N, N, 32'h0,         N, 32'h0,         Y, Y, 32'h108,       N, 32'h0, 32'h0, N));
      apply(vec(N, N, Y, 32'hA000_0104, N, 32'h0,         Y, Y, 32'h108,       N, 32'h0, 32'h0, N));
      apply(vec(N, N, N, 32'h0,         N, 32'h0,         Y, Y, 32'h108,       Y, 32'h104, 32'hA000_0104, Y));

      // Unaligned redirect near the top of memory, then wrap to 0; fill the FIFO.
      apply(vec(N, N, N, 32'h0,         Y, 32'hFFFF_FFFE, Y, Y, 32'h108,       N, 32'h0, 32'h0, N));
      apply(vec(N, Y, N, 32'h0,         N, 32'h0,         N, Y, 32'hFFFF_FFFC, N, 32'h0, 32'h0, N));
      apply(vec(N, Y, Y, 32'hAFFF_FFFC, N, 32'h0,         N, Y, 32'h0,         N, 32'h0, 32'h0, N));
      apply(vec(N, Y, Y, 32'hA000_0000, N, 32'h0,         N, N, 32'h4,         Y, 32'hFFFF_FFFC, 32'hAFFF_FFFC, Y));

      // Reset with the FIFO full, then refetch from RESET_PC.
      apply(vec(Y, Y, N, 32'h0,         N, 32'h0,         N, N, 32'h4,         Y, 32'hFFFF_FFFC, 32'hAFFF_FFFC, Y));
      apply(vec(N, Y, N, 32'h0,         N, 32'h0,         N, N, 32'h0,         N, 32'h0, NOP_INSTR, Y));
      apply(vec(N, Y, N, 32'h0,         N, 32'h0,         Y, Y, 32'h0,         N, 32'h0, 32'h0, N));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage directly upstream of the decode stage. Generates sequential PCs, issues requests to instruction memory, and buffers returned words with their PCs in a small in-order FIFO. Presents one `{pc, instruction}` pair per cycle to decode under a valid/ready handshake. A redirect from execute flushes the FIFO and discards in-flight responses.

## Interface
- `FIFO_DEPTH`, 2: entries in the response FIFO; also the cap on outstanding requests plus buffered entries; legal range ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `imemReq` out 1: request valid.
- `imemAddr` out 32: word-aligned request address.
- `imemReady` in 1: memory accepts the request this cycle.
- `imemRvalid` in 1: response valid; responses return in order, latency ≥1.
- `imemRdata` in 32: response instruction word.
- `redirectValid` in 1: control-flow change this cycle.
- `redirectPc` in 32: new fetch address; bits [1:0] are ignored and treated as 00.
- `idValid` out 1: `instructionSet`/`pcOut` valid.
- `idReady` in 1: decode consumes the current entry.
- `instructionSet` out 32: instruction to decode.
- `pcOut` out 32: PC of `instructionSet`.

## Operation
- **States:**
  - IDLE: the cycle after reset; no request.
  - RUN
  - FLUSH: discarding stale responses.
- **Transitions:**
  - IDLE→RUN unconditionally.
  - RUN→FLUSH on `redirectValid` when `dropCount` would be >0.
  - FLUSH→RUN when `dropCount` reaches 0.
  - Any state→FLUSH or RUN on `redirectValid`, chosen by the new `dropCount`.
- **Issue:** in RUN, `imemReq`=1 when `outstanding + fifoCount − pop < FIFO_DEPTH`, where pop = `idValid & idReady`. An accepted request (`imemReq & imemReady`) advances `fetchPc` by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). `imemAddr` = `fetchPc`.
- **Tracking:** a PC-tag queue of `FIFO_DEPTH` entries records the address of each accepted request. A response pops the tag and pushes `{tag, imemRdata}` into the FIFO.
- **Redirect:** `fetchPc` ← `redirectPc & ~3`. FIFO and tag queue cleared. `dropCount` ← outstanding, including a request accepted that same cycle and excluding a response arriving that same cycle (that response is itself discarded). No requests issue in FLUSH. Each `imemRvalid` in FLUSH decrements `dropCount` and writes nothing.
- **Redirect in FLUSH:** replaces `fetchPc`; `dropCount` is recomputed from the current outstanding count.
- `imemRvalid` is ignored in IDLE. Instruction memory shares `reset`.
- **Output:** `idValid` = FIFO non-empty. `instructionSet`/`pcOut` come from the FIFO head and stay stable while `idValid & ~idReady`.
- **Widths:** `outstanding` and `fifoCount` are each `$clog2(FIFO_DEPTH+1)` bits; `dropCount` uses the same width.

## Timing
- **Reset values:**
  - `imemReq`=0
  - `imemAddr`=`RESET_PC`
  - `idValid`=0
  - `instructionSet`=32'h0000_0013 (NOP)
  - `pcOut`=0
  - state=IDLE
  - all counters 0
- **First request:** cycle 1 after `reset` deasserts, at `RESET_PC`.
- **Latency:** request accepted at t, response at t+L (L≥1), `idValid` at t+L+1.
- **Throughput:** one instruction per cycle with L=1 and `FIFO_DEPTH`≥2.
- **Redirect at t:** `idValid`=0 at t+1. If outstanding=0, the first request at the new PC is at t+1. A pop coinciding with a redirect is ignored (flush wins).
- **FIFO full with `idReady`=0:** issue stops; no response is ever lost, because the credit rule guarantees space.
- **Reset mid-operation:** returns everything to the reset values on the next edge, regardless of outstanding requests.

## Configuration
- **`FETCH_PERF_COUNTERS_EN` defined:** adds output ports `fetchCount[31:0]` (accepted requests) and `stallCount[31:0]` (cycles with `idValid & ~idReady`). Both reset to 0 and wrap at 2^32.
- **Undefined:** the ports and counters do not exist; all other behaviour is identical.

## Structure
- **`instructionList` package gains:**
  - `NOP_INSTR` = 32'h0000_0013
  - `DEFAULT_RESET_PC`
  - a `fetchEntry_t` struct `{pc[31:0], instr[31:0]}`
  - a `fetchState_t` enum `{IDLE, RUN, FLUSH}`
- **Sub-module `fetch_fifo`:** parameterised depth, `fetchEntry_t` payload, push/pop/flush, count output. Instantiated once for responses. The PC-tag queue reuses it with the instr field unused.

## Test plan
- **Reset and stream:** `reset` for 3 cycles, L=1, `idReady`=1 → requests at 0x0, 0x4, 0x8 on consecutive cycles. `idValid` from cycle 3, `pcOut` 0x0, 0x4, 0x8 with the matching `imemRdata`.
- **Back-pressure:** `idReady`=0 for 6 cycles → at most 2 requests outstanding/buffered, `instructionSet` held stable. Release → no skipped or duplicated PCs.
- **Redirect with 2 in flight, L=3:** `redirectPc`=0x104 → both stale responses dropped, next request at 0x104 after FLUSH, first `pcOut`=0x104.
- **Simultaneous events:** redirect, response and pop all at t → `idValid`=0 at t+1, that response is discarded, next request at the new PC.
- **Wrap and alignment:** redirect to 0xFFFF_FFFE → requests at 0xFFFF_FFFC then 0x0000_0000.
- **Mid-stream reset:** reset asserted with FIFO full → all outputs at reset values next cycle, refetch from `RESET_PC`. With `FETCH_PERF_COUNTERS_EN`, `fetchCount`=0.
